// File: rtl/sub_div_ctrl_if.sv
// Operand/result bundle for the sequential restoring divider.
interface sub_div_ctrl_if;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_zero;

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_zero
  );

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_zero
  );
endinterface

// File: rtl/sub_div_ctrl.sv
// 32-bit unsigned restoring divider, one quotient bit per RUN cycle,
// with every trial subtraction routed through a single ripple subtractor.

module bit32s (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] d_o,
  output logic        b_out_o
);
  logic [32:0] bw;

  assign bw[0] = 1'b0;
  for (genvar i = 0; i < 32; i++) begin : g_fs
    assign d_o[i]    = a_i[i] ^ b_i[i] ^ bw[i];
    assign bw[i + 1] = (~a_i[i] & (b_i[i] | bw[i])) | (b_i[i] & bw[i]);
  end
  assign b_out_o = bw[32];
endmodule

module sub_div_ctrl (
  input logic          clk,
  input logic          rst,
  sub_div_ctrl_if.slave bus
);
  localparam int unsigned W  = 32;
  localparam int unsigned CW = 5;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   dvd_q, dvd_d;
  logic [W-1:0]   dvs_q, dvs_d;
  logic [W-1:0]   p_q, p_d;
  logic [W-1:0]   qw_q, qw_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   quo_q, quo_d;
  logic [W-1:0]   rem_q, rem_d;
  logic           dz_q, dz_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  logic [W-1:0]   shift_c;
  logic [W-1:0]   diff_c;
  logic           borrow_c;
  logic           take_c;

  // Trial subtraction of the divisor from the shifted partial remainder.
  assign shift_c = {p_q[W-2:0], dvd_q[W-1]};

  bit32s u_sub (
    .a_i     (shift_c),
    .b_i     (dvs_q),
    .d_o     (diff_c),
    .b_out_o (borrow_c)
  );

  // A shifted-out 1 means S exceeds 2^32 and therefore the divisor.
  assign take_c = p_q[W-1] | ~borrow_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      p_q     <= '0;
      qw_q    <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      p_q     <= p_d;
      qw_q    <= qw_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    p_d     = p_q;
    qw_d    = qw_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dz_d    = dz_q;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (bus.start) begin
          quo_d = '0;
          rem_d = '0;
          dz_d  = 1'b0;
          if (bus.divisor == '0) begin
            state_d = DONE;
            quo_d   = '1;
            rem_d   = bus.dividend;
            dz_d    = 1'b1;
          end else begin
            state_d = RUN;
            dvd_d   = bus.dividend;
            dvs_d   = bus.divisor;
            p_d     = '0;
            qw_d    = '0;
            cnt_d   = '0;
          end
        end
      end
      RUN: begin
        p_d   = take_c ? diff_c : shift_c;
        qw_d  = {qw_q[W-2:0], take_c};
        dvd_d = {dvd_q[W-2:0], 1'b0};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(W - 1)) begin
          state_d = DONE;
          quo_d   = qw_d;
          rem_d   = p_d;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.quotient  = quo_q;
  assign bus.remainder = rem_q;
  assign bus.div_zero  = dz_q;
endmodule

// File: tb/tb_sub_div_ctrl.sv
// Scoreboard bench for sub_div_ctrl: stimulus pushes expected results,
// a negedge monitor pops and compares on every done pulse.
module tb_sub_div_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned cyc = 0;
  int unsigned n_chk = 0;
  int unsigned n_pass = 0;
  int unsigned busy_cnt = 0;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    int unsigned dcyc;
  } exp_t;

  exp_t sb[$];

  sub_div_ctrl_if bus ();

  sub_div_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, expv, cyc);
  endtask

  // Reference: plain integer division, divide-by-zero convention from the datasheet.
  task automatic push_exp(input logic [31:0] a, input logic [31:0] b, input int unsigned acc);
    exp_t e;
    if (b == 32'd0) begin
      e.q = 32'hFFFF_FFFF; e.r = a; e.dz = 1'b1; e.dcyc = acc;
    end else begin
      e.q = a / b; e.r = a % b; e.dz = 1'b0; e.dcyc = acc + 32;
    end
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Called one tick after an edge with the DUT in IDLE or DONE.
  task automatic accept(input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1; bus.dividend = a; bus.divisor = b;
    step();
    push_exp(a, b, cyc);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!bus.done && n < 100) begin step(); n++; end
    if (!bus.done) chk("done_timeout", 32'(n), 32'd0);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_busy"}, 32'(bus.busy), 32'd0);
    chk({nm, "_done"}, 32'(bus.done), 32'd0);
    chk({nm, "_quot"}, bus.quotient, 32'd0);
    chk({nm, "_rem"},  bus.remainder, 32'd0);
    chk({nm, "_dz"},   32'(bus.div_zero), 32'd0);
  endtask

  // Monitor: compare every done pulse against the scoreboard head.
  always @(negedge clk) begin
    if (rst) busy_cnt = 0;
    else begin
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        if (sb.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
        else begin
          exp_t e;
          e = sb.pop_front();
          chk("quotient",   bus.quotient, e.q);
          chk("remainder",  bus.remainder, e.r);
          chk("div_zero",   32'(bus.div_zero), 32'(e.dz));
          chk("done_cycle", cyc, e.dcyc);
          chk("busy_cycles", busy_cnt, e.dz ? 32'd0 : 32'd32);
          chk("busy_with_done", 32'(bus.busy), 32'd0);
        end
        busy_cnt = 0;
      end
    end
  end

  initial begin
    logic [31:0] a, b;
    bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b0;
    step();

    accept(32'd100, 32'd7);            bus.start = 1'b0; wait_done(); step();
    accept(32'hFFFF_FFFF, 32'h8000_0000); bus.start = 1'b0; wait_done(); step();
    accept(32'hFFFF_FFFF, 32'd1);      bus.start = 1'b0; wait_done(); step();
    accept(32'd5, 32'd0);              bus.start = 1'b0; wait_done(); step();

    // Start mid-run with new operands must be ignored.
    accept(32'd1000, 32'd13); bus.start = 1'b0;
    repeat (9) step();
    bus.start = 1'b1; bus.dividend = 32'd55; bus.divisor = 32'd0;
    step();
    bus.start = 1'b0;
    wait_done(); step();

    // Reset mid-run aborts without a done pulse.
    bus.start = 1'b1; bus.dividend = 32'd77; bus.divisor = 32'd5;
    step();
    bus.start = 1'b0;
    repeat (19) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_zero("abort");
    repeat (40) step();
    accept(32'd9, 32'd3); bus.start = 1'b0; wait_done(); step();

    // Start held through DONE gives back-to-back operations.
    accept(32'd10, 32'd3);
    bus.dividend = 32'd20; bus.divisor = 32'd6;
    wait_done();
    accept(32'd20, 32'd6);
    bus.start = 1'b0;
    wait_done();

    for (int i = 0; i < 25; i++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: b = $urandom;
        default: b = {1'b1, 31'($urandom)};
      endcase
      if ($urandom_range(0, 1) == 1) a = a >> $urandom_range(0, 31);
      accept(a, b);
      bus.start = 1'b0;
      wait_done();
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) step();
    end

    repeat (3) step();
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/sub_div_ctrl.md
SUB_DIV_CTRL -- requirements
Module: sub_div_ctrl

Interface
REQ-001 SHALL: one clock; reset is synchronous and active-high.
REQ-002 SHALL: clk  input  1  rising-edge clock for all state.
REQ-003 SHALL: rst  input  1  synchronous, active-high reset, sampled on the clk rising edge.
REQ-004 SHALL: start  input  1  request a division; sampled only in IDLE or DONE.
REQ-005 SHALL: dividend  input  32  unsigned dividend, captured when start is accepted.
REQ-006 SHALL: divisor  input  32  unsigned divisor, captured when start is accepted.
REQ-007 SHALL: busy  output  1  high while state is RUN.
REQ-008 SHALL: done  output  1  high for exactly one cycle when results become valid.
REQ-009 SHALL: quotient  output  32  result quotient, held until the next accepted start.
REQ-010 SHALL: remainder  output  32  result remainder, held until the next accepted start.
REQ-011 SHALL: div_zero  output  1  divisor was zero for the current result; held with the results.

Function
REQ-012 SHALL: instantiate exactly one bit32s 32-bit ripple subtractor; all trial subtractions go through it, with no second subtractor.
REQ-013 SHALL: implement a three-state FSM: IDLE, RUN, DONE.
REQ-014 SHALL: in IDLE or DONE, start=1 with divisor!=0 latches the operands, clears the partial remainder P and the 5-bit counter, and moves to RUN.
REQ-015 SHALL: in IDLE or DONE, start=1 with divisor==0 goes directly to DONE with quotient=32'hFFFFFFFF, remainder=dividend, div_zero=1.
REQ-016 SHALL: any accepted start clears div_zero, quotient and remainder on that edge, except as set by REQ-015.
REQ-017 SHALL: perform one restoring step per RUN cycle, MSB first:
- shifted value S = {P[30:0], next dividend bit}; shifted-out bit c = P[31].
- subtractor computes D = S - divisor, with borrow b_out.
REQ-018 SHALL: if c==1 or b_out==0, set P to D and shift quotient bit 1; otherwise set P to S and shift quotient bit 0.
REQ-019 SHALL: leave RUN for DONE after exactly 32 RUN edges, with the counter wrapping from 31 to 0.
REQ-020 SHALL: make done=1 in the cycle after the 32nd RUN edge, so done is high 32 cycles after the start-accept edge.
REQ-021 SHALL: in the divisor==0 case, make done=1 in the cycle immediately after the start-accept edge.
REQ-022 SHALL: move from DONE to IDLE on the next edge when start=0, or to RUN / DONE per REQ-014 / REQ-015 when start=1, giving back-to-back operation.
REQ-023 SHALL: ignore start while in RUN; operands, counter and results are unaffected.
REQ-024 SHALL: keep quotient and remainder updating only internally during RUN; the visible outputs change only on the edge entering DONE.
REQ-025 SHALL: hold done=0 and busy=0 simultaneously outside RUN and DONE; done and busy are never both 1.

Reset
REQ-026 SHALL: rst=1 forces state IDLE, busy=0, done=0, div_zero=0, quotient=0, remainder=0, P=0 and counter=0 on that edge.
REQ-027 SHALL: rst takes priority over start and over any RUN step, including mid-operation; no done pulse follows an aborted division.
REQ-028 SHALL: the first start accepted after rst is deasserted behaves identically to a start from power-on IDLE.

Verification
REQ-029 SHALL: dividend=100, divisor=7, start pulse -> busy for 32 cycles, then done=1 once, quotient=14, remainder=2, div_zero=0.
REQ-030 SHALL: dividend=32'hFFFFFFFF, divisor=32'h80000000 -> quotient=1, remainder=32'h7FFFFFFF (checks the c==1 path); and dividend=32'hFFFFFFFF, divisor=1 -> quotient=32'hFFFFFFFF, remainder=0.
REQ-031 SHALL: dividend=5, divisor=0 -> done=1 on the cycle after the start edge, quotient=32'hFFFFFFFF, remainder=5, div_zero=1, busy never asserted.
REQ-032 SHALL: start=1 with new operands at RUN cycle 10 -> ignored; the result matches the original operands and done is on schedule.
REQ-033 SHALL: rst asserted at RUN cycle 20 -> all outputs 0, state IDLE, no done pulse; a subsequent 9/3 gives quotient=3, remainder=0.
REQ-034 SHALL: start held high through DONE (10/3 followed by 20/6) -> back-to-back RUN; results 3/1 then 3/2, each with a single done pulse.
